// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: sizes, FSM states and
// the per-state status outputs.
package imem_pkg;

    localparam int IMEM_DEPTH  = 256;
    localparam int IMEM_ADDR_W = 8;
    localparam int INSTR_W     = 32;
    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 28;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CHK,
        DONE,
        ERR
    } loader_state_t;

    typedef struct packed {
        logic rx_ready;
        logic busy;
        logic done;
        logic error;
        logic cpu_hold;
    } loader_status_t;

    // Status outputs are a pure function of the state being entered, so the
    // FSM registers them alongside the state.
    function automatic loader_status_t state_status(loader_state_t s, logic hold_idle);
        loader_status_t st;
        st.rx_ready = (s == HDR) || (s == DATA) || (s == CHK);
        st.busy     = st.rx_ready;
        st.done     = (s == DONE);
        st.error    = (s == ERR);
        st.cpu_hold = (s == IDLE) ? hold_idle : (s != DONE);
        return st;
    endfunction

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(logic [INSTR_W-1:0] w);
        return w[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = byte source / memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/word_assembler.sv
// Collects four stream bytes into one big-endian word; the first byte lands in
// the top byte. word/word_valid are combinational on the fourth byte.
module word_assembler
    import imem_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               byte_valid,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word,
    output logic               word_valid
);

    logic [INSTR_W-9:0] shift_q;
    logic [1:0]         count_q;

    // NOTE: the shift register is datapath, but clearing it keeps a fresh load
    // from ever seeing stale bytes and makes word deterministic after reset.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (byte_valid) begin
            shift_q <= {shift_q[INSTR_W-17:0], byte_in};
            count_q <= count_q + 2'd1;
        end
    end

    assign word       = {shift_q, byte_in};
    assign word_valid = byte_valid && (count_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a program image from a byte stream into instruction memory, checks
// its XOR checksum and holds the CPU until a load has passed.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH         = IMEM_DEPTH,
    parameter int ADDR_W        = IMEM_ADDR_W,
    parameter int BASE_ADDR     = 0,
    parameter int TIMEOUT_CYC   = 1000000,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [ADDR_W:0] words_loaded
);

    localparam int                TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_W  = ADDR_W'(BASE_ADDR);

    loader_state_t     state_q;
    loader_status_t    status_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [INSTR_W-1:0] imem_wdata_q;
    logic [INSTR_W-1:0] xor_q;
    logic [ADDR_W:0]   n_words_q;
    logic [ADDR_W:0]   words_rx_q;
    logic [ADDR_W:0]   words_loaded_q;
    logic [TO_W-1:0]   to_cnt_q;

    logic               xfer;
    logic               asm_clear;
    logic               asm_valid;
    logic [INSTR_W-1:0] asm_word;
    logic               asm_word_valid;

    assign xfer      = bus.rx_valid && status_q.rx_ready;
    assign asm_clear = start && (state_q inside {IDLE, DONE, ERR});
    assign asm_valid = xfer && (state_q inside {DATA, CHK});

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_in    (bus.rx_data),
        .word       (asm_word),
        .word_valid (asm_word_valid)
    );

    // NOTE: every register here uses non-blocking assignment so all of them
    // sample pre-edge values; later assignments in the block take priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            status_q       <= state_status(IDLE, HOLD_AT_RESET);
            imem_we_q      <= 1'b0;
            imem_addr_q    <= BASE_W;
            imem_wdata_q   <= '0;
            xor_q          <= '0;
            n_words_q      <= '0;
            words_rx_q     <= '0;
            words_loaded_q <= '0;
            to_cnt_q       <= '0;
        end else begin
            imem_we_q <= 1'b0;

            // Address and count advance in the cycle after each strobe.
            if (imem_we_q) begin
                imem_addr_q <= imem_addr_q + 1'b1;
                if (words_loaded_q != DEPTH_W) begin
                    words_loaded_q <= words_loaded_q + 1'b1;
                end
            end

            if (status_q.busy) begin
                if (xfer) begin
                    to_cnt_q <= '0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_q  <= ERR;
                    status_q <= state_status(ERR, HOLD_AT_RESET);
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end

            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_q        <= HDR;
                        status_q       <= state_status(HDR, HOLD_AT_RESET);
                        to_cnt_q       <= '0;
                        imem_addr_q    <= BASE_W;
                        words_loaded_q <= '0;
                        words_rx_q     <= '0;
                        xor_q          <= '0;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        n_words_q <= (bus.rx_data == 8'd0) ? DEPTH_W : (ADDR_W + 1)'(bus.rx_data);
                        state_q   <= DATA;
                        status_q  <= state_status(DATA, HOLD_AT_RESET);
                    end
                end
                DATA: begin
                    if (asm_word_valid) begin
                        imem_we_q    <= 1'b1;
                        imem_wdata_q <= asm_word;
                        xor_q        <= xor_q ^ asm_word;
                        words_rx_q   <= words_rx_q + 1'b1;
                        if (words_rx_q + 1'b1 == n_words_q) begin
                            state_q  <= CHK;
                            status_q <= state_status(CHK, HOLD_AT_RESET);
                        end
                    end
                end
                CHK: begin
                    if (asm_word_valid) begin
                        state_q  <= (asm_word == xor_q) ? DONE : ERR;
                        status_q <= state_status((asm_word == xor_q) ? DONE : ERR, HOLD_AT_RESET);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    status_q <= state_status(IDLE, HOLD_AT_RESET);
                end
            endcase
        end
    end

    assign bus.rx_ready   = status_q.rx_ready;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign cpu_hold       = status_q.cpu_hold;
    assign busy           = status_q.busy;
    assign done           = status_q.done;
    assign error          = status_q.error;
    assign words_loaded   = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame-level bench for imem_loader with a queue-based write model
// and per-cycle output comparison.
module tb_imem_loader;
    import imem_pkg::*;

    localparam int T_OUT = 16;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       cpu_hold, busy, done, error;
    logic [8:0] words_loaded;

    imem_loader_if #(.ADDR_W(8)) bus ();

    imem_loader #(
        .DEPTH         (256),
        .ADDR_W        (8),
        .BASE_ADDR     (0),
        .TIMEOUT_CYC   (T_OUT),
        .HOLD_AT_RESET (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          at;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         e_cur;
    logic [7:0]  exp_addr = 8'd0;
    logic [31:0] fw[256];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        prev_we  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] xor_of(input int n);
        logic [31:0] x = '0;
        for (int i = 0; i < n; i++) x ^= fw[i];
        return x;
    endfunction

    // Every write strobe must match the next expected (addr, data, cycle).
    always @(negedge clk) begin
        if (!rst) begin
            check("status_consistency", {bus.rx_ready, cpu_hold, done & error}, {busy, ~done, 1'b0});
            if (bus.imem_we) begin
                check("we_single_cycle", prev_we, 1'b0);
                check("we_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e_cur = exp_q.pop_front();
                    check("wr_addr", bus.imem_addr, e_cur.addr);
                    check("wr_data", bus.imem_wdata, e_cur.data);
                    check("wr_cycle", cyc, e_cur.at);
                end
            end
            prev_we = bus.imem_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap, output int at);
        bit got = 1'b0;
        at = -1;
        repeat (gap) begin
            @(negedge clk);
            start        = 1'b0;
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            start        = 1'b0;
            bus.rx_valid = 1'b1;
            bus.rx_data  = b;
            if (bus.rx_ready) begin
                got = 1'b1;
                at  = cyc;
            end
        end
        check("byte_accepted", got, 1'b1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start        = 1'b1;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        start    = 1'b0;
        exp_addr = 8'd0;
        check("start_busy", busy, 1'b1);
        check("start_clears_done", done, 1'b0);
        check("start_clears_error", error, 1'b0);
        check("start_clears_words", words_loaded, 0);
    endtask

    function automatic int pick_gap(input int gap);
        return (gap < 0) ? int'($urandom_range(0, 3)) : gap;
    endfunction

    // Full load of fw[0..n-1]; gap<0 means random gaps, glitch_at>=0 pulses
    // start just before that data byte.
    task automatic run_frame(input int hdr, input logic [31:0] chk, input int gap, input int glitch_at);
        int  n  = (hdr == 0) ? 256 : hdr;
        int  at;
        int  idx = 0;
        bit  ok  = (chk == xor_of(n));
        logic [31:0] w;
        pulse_start();
        send_byte(8'(hdr), (gap < 0) ? pick_gap(gap) : 0, at);
        for (int i = 0; i < n; i++) begin
            w = fw[i];
            for (int j = 0; j < 4; j++) begin
                if (idx == glitch_at) begin
                    @(negedge clk);
                    bus.rx_valid = 1'b0;
                    start        = 1'b1;
                end
                send_byte(w[31-8*j -: 8], pick_gap(gap), at);
                if (j == 3) begin
                    exp_q.push_back('{addr: exp_addr, data: w, at: at + 1});
                    exp_addr++;
                end
                idx++;
            end
        end
        for (int j = 0; j < 4; j++) send_byte(chk[31-8*j -: 8], pick_gap(gap), at);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("end_done", done, ok);
        check("end_error", error, !ok);
        check("end_cpu_hold", cpu_hold, !ok);
        check("end_busy", busy, 1'b0);
        check("end_rx_ready", bus.rx_ready, 1'b0);
        check("end_words_loaded", words_loaded, n);
        check("end_pending_writes", exp_q.size(), 0);
    endtask

    task automatic load_case1();
        fw[0] = 32'h51C00003;
        fw[1] = 32'h41872000;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          at;
        int          n;
        logic [31:0] chk;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_rx_ready", bus.rx_ready, 1'b0);
        check("rst_imem_we", bus.imem_we, 1'b0);
        check("rst_imem_addr", bus.imem_addr, 0);
        check("rst_imem_wdata", bus.imem_wdata, 0);
        check("rst_busy_done_error", {busy, done, error}, 3'b000);
        check("rst_cpu_hold", cpu_hold, 1'b1);
        check("rst_words_loaded", words_loaded, 0);

        // Hand-computed pins of the model on the reference frame.
        load_case1();
        check("model_xor_literal", xor_of(2), 32'h10472003);
        check("model_opcode_literal", opcode_of(fw[0]), 4'h5);

        run_frame(2, 32'h10472003, 0, -1);
        run_frame(2, 32'h10472004, 0, -1);
        run_frame(2, 32'h10472003, 5, -1);
        run_frame(2, 32'h10472003, T_OUT - 1, -1);

        // Stall mid-DATA past the timeout.
        pulse_start();
        send_byte(8'd3, 0, at);
        for (int j = 0; j < 6; j++) begin
            send_byte(fw[j / 4][31-8*(j%4) -: 8], 1, at);
            if (j == 3) begin
                exp_q.push_back('{addr: exp_addr, data: fw[0], at: at + 1});
                exp_addr++;
            end
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (T_OUT + 3) @(negedge clk);
        check("timeout_error", error, 1'b1);
        check("timeout_done", done, 1'b0);
        check("timeout_rx_ready", bus.rx_ready, 1'b0);
        check("timeout_words_loaded", words_loaded, 1);
        check("timeout_pending_writes", exp_q.size(), 0);

        // Reset after two data bytes, then a normal load.
        pulse_start();
        send_byte(8'd2, 0, at);
        send_byte(fw[0][31:24], 0, at);
        send_byte(fw[0][23:16], 0, at);
        @(negedge clk);
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_rx_ready", bus.rx_ready, 1'b0);
        check("midrst_status", {busy, done, error, cpu_hold}, 4'b0001);
        check("midrst_words_loaded", words_loaded, 0);
        repeat (6) @(negedge clk);
        check("midrst_no_write", bus.imem_we, 1'b0);
        run_frame(2, 32'h10472003, 0, -1);

        // start during DATA is ignored; a later start reloads from address 0.
        run_frame(2, 32'h10472003, 0, 3);
        run_frame(2, 32'h10472003, -1, -1);

        // Header 0 => full 256-word image.
        for (int i = 0; i < 256; i++) fw[i] = $urandom;
        run_frame(0, xor_of(256), -1, -1);

        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) fw[i] = $urandom;
            chk = xor_of(n);
            if ($urandom_range(0, 2) == 0) chk ^= 32'(1) << $urandom_range(0, 31);
            run_frame(n, chk, -1, (k == 2) ? int'($urandom_range(4, 4 * n - 1)) : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
